// File: rtl/mcu_sw_poller_pkg.sv
// mcu_sw_poller_pkg: shared FSM state type and slave register map for the switch poller.
package mcu_sw_poller_pkg;
  typedef enum logic [1:0] {IDLE, REQ, CAPT} state_t;
  localparam logic [1:0] ADDR_STATE  = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_EDGE   = 2'd3;
endpackage

// File: rtl/mcu_sw_debounce.sv
// mcu_sw_debounce: whole-vector debouncer; accepts a new value after STABLE_CNT identical samples.
module mcu_sw_debounce #(
  parameter int WIDTH      = 3,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             strobe,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] deb,
  output logic             upd
);
  localparam int CW = $clog2(STABLE_CNT);
  localparam logic [CW-1:0] TOP = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  logic [WIDTH-1:0] prev;
  logic [CW-1:0] cnt, cnt_n;
  always_comb begin
    cnt_n = data != prev ? '0 : cnt == TOP ? cnt : cnt + ONE;
    upd = strobe && cnt_n == TOP && data != deb;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev <= '0;
      cnt  <= '0;
      deb  <= '0;
    end else if (strobe) begin
      prev <= data;
      cnt  <= cnt_n;
      if (upd) deb <= data;
    end
endmodule

// File: rtl/mcu_sw_poller.sv
// mcu_sw_poller: polls the switch PIO over Avalon-MM, debounces it, captures edges and raises a maskable irq.
module mcu_sw_poller
  import mcu_sw_poller_pkg::*;
#(
  parameter int WIDTH          = 3,
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 50000,
  parameter int STABLE_CNT     = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
  state_t state;
  logic [PERIOD_W-1:0] cnt, period;
  logic [WIDTH-1:0] deb, mask, edge_cap, set_bits, clr_bits;
  logic [31:0] rd_mux;
  logic upd;
  logic unused_bits;
  assign unused_bits = ^{s_writedata, m_readdata};
  assign m_address = 2'd0;
  mcu_sw_debounce #(.WIDTH(WIDTH), .STABLE_CNT(STABLE_CNT)) u_deb (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (state == CAPT),
    .data   (m_readdata[WIDTH-1:0]),
    .deb    (deb),
    .upd    (upd)
  );
  always_comb begin
    set_bits = upd ? deb ^ m_readdata[WIDTH-1:0] : '0;
    clr_bits = s_write && s_address == ADDR_EDGE ? s_writedata[WIDTH-1:0] : '0;
    rd_mux = s_address == ADDR_STATE  ? 32'(deb) :
             s_address == ADDR_PERIOD ? 32'(period) :
             s_address == ADDR_MASK   ? 32'(mask) : 32'(edge_cap);
  end
  // Reload uses the period live at CAPT, so period writes never disturb a count in progress.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= PERIOD_W'(DEFAULT_PERIOD - 1);
      m_read <= 1'b0;
    end else
      case (state)
        IDLE:
          if (cnt == '0) begin
            state  <= REQ;
            m_read <= 1'b1;
          end else cnt <= cnt - ONE;
        REQ:
          if (!m_waitrequest) begin
            state  <= CAPT;
            m_read <= 1'b0;
          end
        CAPT: begin
          state <= IDLE;
          cnt   <= period == '0 ? '0 : period - ONE;
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      period     <= PERIOD_W'(DEFAULT_PERIOD);
      mask       <= '0;
      edge_cap   <= '0;
      s_readdata <= '0;
      irq        <= 1'b0;
    end else begin
      if (s_write && s_address == ADDR_PERIOD) period <= s_writedata[PERIOD_W-1:0];
      if (s_write && s_address == ADDR_MASK) mask <= s_writedata[WIDTH-1:0];
      edge_cap <= (edge_cap & ~clr_bits) | set_bits;
      if (s_read) s_readdata <= rd_mux;
      irq <= |(edge_cap & mask);
    end
endmodule

// File: tb/tb_mcu_sw_poller.sv
// tb_mcu_sw_poller: directed plus randomized checks against a sample-history model of the poller.
module tb_mcu_sw_poller;
  localparam int DP = 20;
  localparam int S  = 4;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [1:0] m_address, s_address;
  logic m_read, m_waitrequest, s_read, s_write, irq;
  logic [31:0] m_readdata, s_writedata, s_readdata;
  always #5 clk = ~clk;
  mcu_sw_poller #(.WIDTH(3), .PERIOD_W(16), .DEFAULT_PERIOD(DP), .STABLE_CNT(S)) dut (
    .clk(clk), .reset_n(reset_n), .m_address(m_address), .m_read(m_read),
    .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .s_address(s_address),
    .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .irq(irq)
  );
  int passed = 0, failed = 0, total = 0, cyc = 0, exp_rise = 0, ws = 0, force_ws = -1;
  logic [2:0] sw = '0, e_deb = '0, e_edge = '0, e_mask = '0, pend_v = '0;
  logic [15:0] e_period = 16'(DP);
  bit pend = 0, w1c_flag = 0, mr_prev = 0, wr_prev = 0;
  logic [2:0] hist[$];
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s got %0h expected %0h", tag, o, e);
    end
  endtask
  function automatic int eff(input logic [15:0] p);
    return p == 16'd0 ? 1 : int'(p);
  endfunction
  // A new value is accepted once the last S samples all agree and differ from the debounced value.
  task automatic capture(input logic [2:0] v, output logic [2:0] set);
    int same = 0;
    set = '0;
    hist.push_back(v);
    if (hist.size() > S) void'(hist.pop_front());
    foreach (hist[i]) if (hist[i] == v) same++;
    if (same == S && v != e_deb) begin
      set = e_deb ^ v;
      e_deb = v;
    end
  endtask
  task automatic model_reset();
    e_deb = '0; e_edge = '0; e_mask = '0; e_period = 16'(DP);
    hist.delete(); pend = 0; ws = 0; force_ws = -1; w1c_flag = 0;
  endtask
  task automatic tick();
    bit acc, wr;
    logic [1:0] wa;
    logic [31:0] wd, r;
    logic irq_n;
    logic [2:0] set, clr;
    acc = m_read && !m_waitrequest;
    wr = s_write; wa = s_address; wd = s_writedata;
    irq_n = |(e_edge & e_mask);
    mr_prev = m_read; wr_prev = m_waitrequest;
    set = '0; clr = '0;
    @(posedge clk); #1;
    cyc++;
    s_read = 1'b0; s_write = 1'b0;
    if (pend) capture(pend_v, set);
    if (wr && wa == 2'd3) clr = wd[2:0];
    e_edge = (e_edge & ~clr) | set;
    if (wr && wa == 2'd1) e_period = wd[15:0];
    if (wr && wa == 2'd2) e_mask = wd[2:0];
    pend = acc;
    r = $urandom;
    if (acc) begin
      pend_v = sw;
      m_readdata = {r[31:3], sw};
      exp_rise = cyc + 1 + eff(e_period);
      if (w1c_flag) begin
        s_write = 1'b1; s_address = 2'd3; s_writedata = 32'd1; w1c_flag = 0;
      end
    end else m_readdata = r;
    chk("irq", 32'(irq), 32'(irq_n));
    chk("m_address", 32'(m_address), 32'd0);
    if (mr_prev && wr_prev) chk("m_read_hold", 32'(m_read), 32'd1);
    if (m_read && !mr_prev) begin
      chk("issue_cycle", 32'(cyc), 32'(exp_rise));
      ws = force_ws >= 0 ? force_ws : $urandom_range(0, 3);
      force_ws = -1;
    end
    m_waitrequest = m_read ? (ws > 0) : 1'($urandom_range(0, 1));
    if (m_read && ws > 0) ws--;
  endtask
  task automatic rd(input logic [1:0] a, input string tag);
    logic [31:0] e;
    e = a == 2'd0 ? 32'(e_deb) : a == 2'd1 ? 32'(e_period) : a == 2'd2 ? 32'(e_mask) : 32'(e_edge);
    s_address = a; s_read = 1'b1;
    tick();
    chk(tag, s_readdata, e);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    tick();
  endtask
  task automatic wait_sample();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!pend && n < 300);
    chk("sample_seen", 32'(pend), 32'd1);
  endtask
  initial begin
    int n;
    logic [2:0] bounce[6];
    bounce = '{3'b101, 3'b000, 3'b101, 3'b101, 3'b101, 3'b101};
    m_readdata = '0; m_waitrequest = 1'b0;
    s_address = '0; s_read = 1'b0; s_write = 1'b0; s_writedata = '0;
    repeat (3) tick();
    chk("reset_m_read", 32'(m_read), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_s_readdata", s_readdata, 32'd0);
    reset_n = 1'b1;
    exp_rise = cyc + DP;
    rd(2'd0, "reset_state"); rd(2'd1, "reset_period"); rd(2'd2, "reset_mask"); rd(2'd3, "reset_edge");
    wr(2'd1, 32'd4);
    sw = 3'b000;
    repeat (3) wait_sample();
    rd(2'd0, "idle_state");
    wr(2'd0, 32'd7);
    rd(2'd0, "state_ro");
    sw = 3'b101;
    repeat (3) wait_sample();
    tick();
    rd(2'd0, "deb_hold");
    chk("deb_hold_const", s_readdata, 32'd0);
    wait_sample();
    tick();
    rd(2'd0, "deb_new");
    chk("deb_new_const", s_readdata, 32'd5);
    rd(2'd3, "edge_new");
    wr(2'd2, 32'hFFFF_FFF9);
    tick();
    chk("irq_after_mask", 32'(irq), 32'd1);
    rd(2'd2, "mask_trunc");
    wr(2'd3, 32'd1);
    tick();
    chk("irq_after_w1c", 32'(irq), 32'd0);
    rd(2'd3, "edge_after_w1c");
    chk("edge_after_w1c_const", s_readdata, 32'd4);
    sw = 3'b000;
    repeat (4) wait_sample();
    tick();
    rd(2'd0, "bounce_base");
    foreach (bounce[i]) begin
      sw = bounce[i];
      wait_sample();
      tick();
      rd(2'd0, "bounce_state");
    end
    chk("bounce_final", s_readdata, 32'd5);
    force_ws = 5;
    wait_sample();
    tick();
    rd(2'd0, "wait_state_sample");
    wr(2'd3, 32'd7);
    sw = 3'b100;
    repeat (3) wait_sample();
    w1c_flag = 1;
    wait_sample();
    tick();
    rd(2'd3, "edge_set_wins");
    chk("edge_set_wins_bit0", 32'(s_readdata[0]), 32'd1);
    for (int i = 0; i < 40; i++) begin
      sw = 3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 6)) wait_sample();
      case ($urandom_range(0, 3))
        0: rd(2'($urandom_range(0, 3)), "rand_rd");
        1: wr(2'd2, 32'($urandom_range(0, 7)));
        2: wr(2'd3, 32'($urandom_range(0, 7)));
        default: wr(2'd1, 32'($urandom_range(0, 6)));
      endcase
      rd(2'd0, "rand_state");
      rd(2'd3, "rand_edge");
    end
    force_ws = 50;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_read && n < 300);
    chk("req_seen", 32'(m_read), 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("reset_drop_m_read", 32'(m_read), 32'd0);
    model_reset();
    m_waitrequest = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    exp_rise = cyc + DP;
    chk("rst2_irq", 32'(irq), 32'd0);
    rd(2'd0, "rst2_state"); rd(2'd1, "rst2_period"); rd(2'd2, "rst2_mask"); rd(2'd3, "rst2_edge");
    sw = 3'b011;
    repeat (4) wait_sample();
    tick();
    rd(2'd0, "rst2_deb");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
